// File: rtl/pkt_buf_mem_pkg.sv
// Shared constants and helpers for the packet-buffer memory and its read pipeline.
package pkt_buf_mem_pkg;

   localparam int unsigned RD_LAT_MIN = 1;
   localparam int unsigned RD_LAT_MAX = 3;

   function automatic int unsigned calc_nbytes(input int unsigned dwidth);
      return dwidth / 8;
   endfunction

   // Even parity: the 9-bit {byte, parity} group always carries an even number of ones.
   function automatic logic parity8(input logic [7:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/pkt_buf_mem_rd_pipe.sv
// Stall-able RD_LAT-stage valid/data/perr read pipeline; the whole pipe freezes while the
// last stage holds a result the consumer has not taken.
module pkt_buf_mem_rd_pipe
   import pkt_buf_mem_pkg::*;
#(
   parameter int unsigned DWIDTH = 32,
   parameter int unsigned RD_LAT = 2,
   parameter int unsigned NBYTES = calc_nbytes(DWIDTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid_i,
   input  logic [DWIDTH-1:0] in_data_i,
   input  logic [NBYTES-1:0] in_perr_i,
   output logic              in_rdy_o,
   input  logic              out_rdy_i,
   output logic              out_valid_o,
   output logic [DWIDTH-1:0] out_data_o,
   output logic [NBYTES-1:0] out_perr_o
);

   logic [RD_LAT-1:0] vld_q, vld_d;
   logic [DWIDTH-1:0] dat_q [RD_LAT];
   logic [DWIDTH-1:0] dat_d [RD_LAT];
   logic [NBYTES-1:0] perr_q [RD_LAT];
   logic [NBYTES-1:0] perr_d [RD_LAT];
   logic              stall;

   assign stall = vld_q[RD_LAT-1] && !out_rdy_i;

   always_comb begin
      vld_d  = vld_q;
      dat_d  = dat_q;
      perr_d = perr_q;
      if (!stall) begin
         // Bubbles advance too; their payload is cleared so rd_data idles at zero.
         vld_d[0]  = in_valid_i;
         dat_d[0]  = in_valid_i ? in_data_i : '0;
         perr_d[0] = in_valid_i ? in_perr_i : '0;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i]  = vld_q[i-1];
            dat_d[i]  = dat_q[i-1];
            perr_d[i] = perr_q[i-1];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_q  <= '0;
         dat_q  <= '{default: '0};
         perr_q <= '{default: '0};
      end else begin
         vld_q  <= vld_d;
         dat_q  <= dat_d;
         perr_q <= perr_d;
      end
   end

   assign in_rdy_o    = !stall;
   assign out_valid_o = vld_q[RD_LAT-1];
   assign out_data_o  = dat_q[RD_LAT-1];
   assign out_perr_o  = perr_q[RD_LAT-1];

endmodule

// File: rtl/pkt_buf_mem.sv
// Byte-enabled packet-buffer memory with a pipelined valid/ready read port and write-first
// collision merge. Define PKT_BUF_MEM_PARITY_EN to store and check per-byte even parity.
module pkt_buf_mem
   import pkt_buf_mem_pkg::*;
#(
   parameter int unsigned DWIDTH = 32,
   parameter int unsigned DEPTH  = 1024,
   parameter int unsigned AWIDTH = $clog2(DEPTH),
   parameter int unsigned RD_LAT = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [AWIDTH-1:0]        wr_addr,
   input  logic [DWIDTH-1:0]        wr_data,
   input  logic [DWIDTH/8-1:0]      wr_be,
   input  logic                     perr_inj,
   input  logic                     rd_req,
   input  logic [AWIDTH-1:0]        rd_addr,
   output logic                     rd_req_rdy,
   output logic                     rd_valid,
   output logic [DWIDTH-1:0]        rd_data,
   input  logic                     rd_rdy,
   output logic [DWIDTH/8-1:0]      rd_perr
);

   localparam int unsigned     NBYTES  = calc_nbytes(DWIDTH);
   localparam logic [AWIDTH:0] DEPTH_W = (AWIDTH+1)'(DEPTH);

   if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
      $error("pkt_buf_mem: RD_LAT must be within 1..3");
   end
   if (DWIDTH % 8 != 0) begin : g_bad_dwidth
      $error("pkt_buf_mem: DWIDTH must be a multiple of 8");
   end

   logic [DWIDTH-1:0] mem_q [DEPTH];
   logic              wr_hit;
   logic              rd_hit;
   logic              rd_acc;
   logic              collide;
   logic [DWIDTH-1:0] arr_word;
   logic [DWIDTH-1:0] rd_word;
   logic [NBYTES-1:0] rd_perr_c;

   assign wr_hit   = wr_en && ({1'b0, wr_addr} < DEPTH_W);
   assign rd_hit   = {1'b0, rd_addr} < DEPTH_W;
   assign rd_acc   = rd_req && rd_req_rdy;
   assign collide  = wr_hit && rd_hit && (wr_addr == rd_addr);
   assign arr_word = mem_q[rd_addr];

   always_ff @(posedge clk) begin
      if (wr_hit) begin
         for (int i = 0; i < NBYTES; i++) begin
            if (wr_be[i]) mem_q[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
         end
      end
   end

`ifdef PKT_BUF_MEM_PARITY_EN
   logic [NBYTES-1:0] par_q [DEPTH];
   logic [NBYTES-1:0] arr_par;
   logic [NBYTES-1:0] stored_par;

   always_ff @(posedge clk) begin
      if (wr_hit) begin
         for (int i = 0; i < NBYTES; i++) begin
            if (wr_be[i]) par_q[wr_addr][i] <= parity8(wr_data[8*i +: 8]) ^ perr_inj;
         end
      end
   end

   assign arr_par = par_q[rd_addr];
`else
   logic unused_perr_inj;
   assign unused_perr_inj = perr_inj;
`endif

   // Write-first merge: enabled bytes of a same-address write bypass the array.
   always_comb begin
      rd_word   = '0;
      rd_perr_c = '0;
`ifdef PKT_BUF_MEM_PARITY_EN
      stored_par = '0;
`endif
      if (rd_hit) begin
         for (int i = 0; i < NBYTES; i++) begin
            if (collide && wr_be[i]) rd_word[8*i +: 8] = wr_data[8*i +: 8];
            else                     rd_word[8*i +: 8] = arr_word[8*i +: 8];
`ifdef PKT_BUF_MEM_PARITY_EN
            if (collide && wr_be[i]) stored_par[i] = parity8(wr_data[8*i +: 8]) ^ perr_inj;
            else                     stored_par[i] = arr_par[i];
            rd_perr_c[i] = parity8(rd_word[8*i +: 8]) ^ stored_par[i];
`endif
         end
      end
   end

   pkt_buf_mem_rd_pipe #(
      .DWIDTH (DWIDTH),
      .RD_LAT (RD_LAT),
      .NBYTES (NBYTES)
   ) u_rd_pipe (
      .clk         (clk),
      .reset       (reset),
      .in_valid_i  (rd_acc),
      .in_data_i   (rd_word),
      .in_perr_i   (rd_perr_c),
      .in_rdy_o    (rd_req_rdy),
      .out_rdy_i   (rd_rdy),
      .out_valid_o (rd_valid),
      .out_data_o  (rd_data),
      .out_perr_o  (rd_perr)
   );

endmodule
